req_ack_2ph_arb: RTL and testbench
==================================

REQ_ACK_2PH_ARB -- requirements
Module: req_ack_2ph_arb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DW, 16, payload width.
- NREQ, 4, number of requesters, 2..16.
- TO_CYC, 255, WAIT-state cycles before timeout is flagged, 1..65535.
- IDW = $clog2(NREQ), derived, source-ID width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_tx, in, 1, transmit-domain clock.
- rst_b, in, 1, asynchronous active-low reset.
- val, in, NREQ, per-requester valid.
- din, in, NREQ x DW, per-requester payload.
- rdy, out, NREQ, per-requester ready.
- ack, in, 1, 2-phase acknowledge from the receive domain (asynchronous).
- req, out, 1, 2-phase request toggle.
- dout, out, DW, launched payload, held stable while in WAIT.
- src, out, IDW, index of the launched requester, held stable while in WAIT.
- busy, out, 1, high while in WAIT.
- timeout_err, out, 1, sticky ack-timeout flag.
- clr_err, in, 1, synchronous clear of timeout_err.

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-004 In IDLE, the arbiter SHALL grant exactly one active val[i], chosen round-robin starting at ptr+1 mod NREQ.
REQ-005 rdy[i] SHALL be 1 only when the state is IDLE and i is the winner; it is combinational from val, state and ptr, so at most one rdy bit is high.
REQ-006 On the edge where val[i] && rdy[i]:
- dout <= din[i], src <= i.
- req toggles, visible the following cycle.
- ptr <= i.
- state <= WAIT.
REQ-007 A requester SHALL keep val and din stable until its rdy is seen; val never depends on rdy.
REQ-008 ack SHALL pass through a 3-flop shift chain; ack_evt = XOR of flops 2 and 3.
REQ-009 In WAIT, ack_evt SHALL return the state to IDLE; a new grant is possible in that same IDLE cycle.
REQ-010 Latency: an ack toggle first sampled at edge k SHALL give IDLE, and rdy, after edge k+2.
REQ-011 An ack_evt seen in IDLE is spurious and SHALL be ignored; ptr and outputs are unchanged.
REQ-012 A 16-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle, saturating at TO_CYC.
REQ-013 When the wait counter reaches TO_CYC, timeout_err SHALL set.
REQ-014 Timeout SHALL NOT abort the transfer: the state stays WAIT until ack_evt, and req is never re-toggled.
REQ-015 clr_err SHALL clear timeout_err on the next edge; if set and clear occur in the same cycle, set wins.
REQ-016 busy SHALL be 1 exactly when the state is WAIT.
REQ-017 With no val active in IDLE, all outputs SHALL hold their values.
REQ-018 Round-robin fairness: with all NREQ requesters continuously valid, each SHALL be granted once per NREQ grants.

Reset
REQ-019 Assertion of rst_b SHALL asynchronously force:
- state = IDLE.
- req = 0, dout = 0, src = 0.
- ptr = NREQ-1, so requester 0 has first priority.
- ack sync flops = 0.
- wait counter = 0, timeout_err = 0.
REQ-020 Reset asserted during WAIT SHALL abandon the transfer; the receive side is reset by the same system reset event.
REQ-021 rdy SHALL be all-zero while rst_b is low and in the first cycle after release if val is 0.

Structure
REQ-022 Package req_ack_2ph_pkg SHALL hold the state enum (IDLE, WAIT) and the default DW, NREQ and TO_CYC constants.
REQ-023 Round-robin selection SHALL be the sub-module rr_arb_pick, a combinational block with inputs val[NREQ] and ptr and outputs a one-hot grant and a valid.
REQ-024 The ack synchronizer, FSM, counter and datapath registers SHALL be in the top module.

Verification
REQ-025 Single transfer: val[2]=1, din[2]=16'hA5A5 -> rdy[2] in the same cycle, req 0->1 next cycle, dout=A5A5, src=2, busy=1; toggle ack -> IDLE after edge k+2.
REQ-026 All four requesters valid with distinct data, ack looped back after 5 cycles -> grant order 0,1,2,3,0; each src matches its data.
REQ-027 Hold ack, TO_CYC=8 -> timeout_err=1 at the 8th WAIT cycle, busy stays 1; then toggle ack -> IDLE with timeout_err still 1; pulse clr_err -> 0.
REQ-028 clr_err asserted in the cycle the timeout sets -> timeout_err=1.
REQ-029 Toggle ack while IDLE with no val -> no state change, req unchanged, no rdy.
REQ-030 Assert rst_b low mid-WAIT -> req=0, busy=0, ptr reset; requester 0 wins next when requesters 0 and 3 are both valid.

Source files
------------

// File: rtl/req_ack_2ph_arb_pkg.sv
// rtl/req_ack_2ph_arb_pkg.sv - shared types and defaults for the 2-phase req/ack arbiter
//
// Purpose : FSM state type and default parameter values used by
//           req_ack_2ph_arb and rr_arb_pick.
// Ports   : none (package).
package req_ack_2ph_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int DEF_DW     = 16;
   localparam int DEF_NREQ   = 4;
   localparam int DEF_TO_CYC = 255;
   localparam int WCNT_W     = 16;

endpackage

// File: rtl/req_ack_2ph_arb_rr_pick.sv
// rtl/req_ack_2ph_arb_rr_pick.sv - combinational round-robin picker
//
// Purpose : picks exactly one active val bit, searching from ptr+1 upward
//           and wrapping modulo NREQ, so the last winner has lowest priority.
// Ports   : val     - per-requester valid
//           ptr     - index of the previous winner
//           gnt     - one-hot grant (all zero when no val is active)
//           gnt_vld - high when gnt has a bit set
module rr_arb_pick
   import req_ack_2ph_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] val,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic            gnt_vld
);

   logic [IDW-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      // k runs 1..NREQ so the previous winner (k == NREQ) is checked last.
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!gnt_vld && val[idx]) begin
            gnt[idx] = 1'b1;
            gnt_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_ack_2ph_arb.sv
// rtl/req_ack_2ph_arb.sv - N-way round-robin arbiter launching onto a 2-phase req/ack link
//
// Purpose : grants one requester at a time, launches its payload with a
//           req toggle, then waits for the matching ack toggle from the
//           receive domain. A sticky flag reports an ack that is late by
//           TO_CYC cycles; the transfer itself is never aborted.
// Ports   : clk_tx      - transmit-domain clock
//           rst_b       - asynchronous active-low reset
//           val/din/rdy - per-requester valid, payload, ready
//           ack         - 2-phase acknowledge (asynchronous)
//           req         - 2-phase request toggle
//           dout/src    - launched payload and requester index
//           busy        - high while waiting for ack
//           timeout_err - sticky ack-timeout flag
//           clr_err     - synchronous clear of timeout_err
module req_ack_2ph_arb
   import req_ack_2ph_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int NREQ   = DEF_NREQ,
   parameter int TO_CYC = DEF_TO_CYC,
   parameter int IDW    = $clog2(NREQ)
) (
   input  logic                    clk_tx,
   input  logic                    rst_b,
   input  logic [NREQ-1:0]         val,
   input  logic [NREQ-1:0][DW-1:0] din,
   output logic [NREQ-1:0]         rdy,
   input  logic                    ack,
   output logic                    req,
   output logic [DW-1:0]           dout,
   output logic [IDW-1:0]          src,
   output logic                    busy,
   output logic                    timeout_err,
   input  logic                    clr_err
);

   localparam logic [WCNT_W-1:0] TO_LIM = WCNT_W'(TO_CYC);

   state_t              state;
   state_t              state_nxt;
   logic [IDW-1:0]      ptr;
   logic [2:0]          ack_sync;
   logic                ack_evt;
   logic [NREQ-1:0]     gnt;
   logic                gnt_vld;
   logic [IDW-1:0]      gnt_idx;
   logic                launch;
   logic                to_hit;
   logic [WCNT_W-1:0]   wcnt;

   rr_arb_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .val     (val),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_vld (gnt_vld)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) gnt_idx = IDW'(i);
      end
   end

   // rst_b is folded in so rdy stays low for the whole reset, not just
   // after the first clock edge under reset.
   assign launch = (state == IDLE) && rst_b && gnt_vld;

   // Flop 0 may go metastable; flops 1 and 2 are stable and their XOR
   // marks exactly one cycle per ack toggle.
   always_ff @(posedge clk_tx or negedge rst_b) begin
      if (!rst_b) ack_sync <= '0;
      else        ack_sync <= {ack_sync[1:0], ack};
   end

   assign ack_evt = ack_sync[1] ^ ack_sync[2];

   always_ff @(posedge clk_tx or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;
   end

   // An ack_evt in IDLE is a stray toggle and is dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch)  state_nxt = WAIT;
         WAIT:    if (ack_evt) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == WAIT);
      rdy  = ((state == IDLE) && rst_b) ? gnt : '0;
   end

   // ptr resets to NREQ-1 so requester 0 is first in line.
   always_ff @(posedge clk_tx or negedge rst_b) begin
      if (!rst_b) begin
         req  <= 1'b0;
         dout <= '0;
         src  <= '0;
         ptr  <= IDW'(NREQ - 1);
      end else if (launch) begin
         req  <= ~req;
         dout <= din[gnt_idx];
         src  <= gnt_idx;
         ptr  <= gnt_idx;
      end
   end

   always_ff @(posedge clk_tx or negedge rst_b) begin
      if (!rst_b) begin
         wcnt <= '0;
      end else if (launch) begin
         wcnt <= '0;
      end else if ((state == WAIT) && (wcnt != TO_LIM)) begin
         wcnt <= wcnt + 1'b1;
      end
   end

   // True on the edge where the count of elapsed WAIT cycles becomes TO_CYC;
   // saturation guarantees this fires only once per transfer.
   assign to_hit = (state == WAIT) && (wcnt == TO_LIM - 1'b1);

   // Set has priority over a same-cycle clear.
   always_ff @(posedge clk_tx or negedge rst_b) begin
      if (!rst_b)       timeout_err <= 1'b0;
      else if (to_hit)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
   end

endmodule

// File: tb/tb_req_ack_2ph_arb.sv
// tb/tb_req_ack_2ph_arb.sv - self-checking bench for req_ack_2ph_arb
module tb_req_ack_2ph_arb;

   localparam int DW     = 16;
   localparam int NREQ   = 4;
   localparam int TO_CYC = 8;
   localparam int IDW    = 2;

   logic                    clk_tx = 1'b0;
   logic                    rst_b;
   logic [NREQ-1:0]         val;
   logic [NREQ-1:0][DW-1:0] din;
   logic [NREQ-1:0]         rdy;
   logic                    ack;
   logic                    req;
   logic [DW-1:0]           dout;
   logic [IDW-1:0]          src;
   logic                    busy;
   logic                    timeout_err;
   logic                    clr_err;

   int n_vec = 0;
   int n_bad = 0;

   logic          exp_req;
   logic [DW-1:0] exp_dout;
   int            exp_src;
   int            q[$];
   int            cnt[NREQ];

   typedef struct {
      logic [NREQ-1:0] v;
      int              w;
      logic [DW-1:0]   d;
   } vec_t;

   vec_t tbl[8];

   req_ack_2ph_arb #(
      .DW     (DW),
      .NREQ   (NREQ),
      .TO_CYC (TO_CYC),
      .IDW    (IDW)
   ) dut (
      .clk_tx      (clk_tx),
      .rst_b       (rst_b),
      .val         (val),
      .din         (din),
      .rdy         (rdy),
      .ack         (ack),
      .req         (req),
      .dout        (dout),
      .src         (src),
      .busy        (busy),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );

   always #5 clk_tx = ~clk_tx;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_tx);
      #1;
   endtask

   task automatic model_init();
      exp_req  = 1'b0;
      exp_dout = '0;
      exp_src  = 0;
      q.delete();
      for (int i = 0; i < NREQ; i++) q.push_back(i);
   endtask

   task automatic do_reset();
      rst_b   = 1'b0;
      val     = '0;
      ack     = 1'b0;
      clr_err = 1'b0;
      repeat (2) tick();
      rst_b = 1'b1;
      model_init();
      tick();
   endtask

   // One complete transfer: grant w out of v, hold WAIT for dly cycles,
   // toggle ack and expect IDLE exactly three edges later.
   task automatic xfer(input logic [NREQ-1:0] v, input int w, input int dly,
                       input logic [DW-1:0] wdata, input string tag);
      for (int i = 0; i < NREQ; i++) din[i] = DW'($urandom);
      din[w] = wdata;
      val    = v;
      #1;
      chk($sformatf("%s rdy", tag), 32'(rdy), 32'(1) << w);
      tick();
      exp_req  = ~exp_req;
      exp_dout = wdata;
      exp_src  = w;
      val      = v & ~(NREQ'(1) << w);
      #1;
      chk($sformatf("%s req", tag), 32'(req), 32'(exp_req));
      chk($sformatf("%s dout", tag), 32'(dout), 32'(exp_dout));
      chk($sformatf("%s src", tag), 32'(src), 32'(exp_src));
      chk($sformatf("%s busy", tag), 32'(busy), 32'd1);
      chk($sformatf("%s rdy_wait", tag), 32'(rdy), 32'd0);
      repeat (dly) tick();
      ack = ~ack;
      repeat (2) tick();
      chk($sformatf("%s busy_k1", tag), 32'(busy), 32'd1);
      tick();
      chk($sformatf("%s busy_k2", tag), 32'(busy), 32'd0);
      val = '0;
   endtask

   initial begin
      int w;
      logic [NREQ-1:0] v;

      tbl[0] = '{4'b0100, 2, 16'hA5A5};
      tbl[1] = '{4'b1111, 3, 16'h1111};
      tbl[2] = '{4'b1111, 0, 16'h2222};
      tbl[3] = '{4'b1001, 3, 16'h3333};
      tbl[4] = '{4'b1001, 0, 16'h4444};
      tbl[5] = '{4'b0001, 0, 16'h5555};
      tbl[6] = '{4'b0110, 1, 16'h6666};
      tbl[7] = '{4'b0011, 0, 16'h7777};

      // Reset state, with every requester valid to prove rdy is gated.
      rst_b   = 1'b0;
      val     = '1;
      din     = '0;
      ack     = 1'b0;
      clr_err = 1'b0;
      repeat (2) tick();
      chk("rst rdy", 32'(rdy), 32'd0);
      chk("rst req", 32'(req), 32'd0);
      chk("rst dout", 32'(dout), 32'd0);
      chk("rst src", 32'(src), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst timeout", 32'(timeout_err), 32'd0);
      val   = '0;
      rst_b = 1'b1;
      model_init();
      #1;
      chk("post_rst rdy", 32'(rdy), 32'd0);
      tick();
      chk("post_rst busy", 32'(busy), 32'd0);

      // Table of grants from the reset pointer onwards.
      for (int i = 0; i < 8; i++)
         xfer(tbl[i].v, tbl[i].w, i % 4, tbl[i].d, $sformatf("tbl%0d", i));

      // All requesters valid: order 0,1,2,3,0,1,2,3 and each granted twice.
      do_reset();
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      for (int i = 0; i < 2 * NREQ; i++) begin
         xfer('1, i % NREQ, 4, DW'(16'h1000 + i), $sformatf("rr%0d", i));
         cnt[i % NREQ]++;
      end
      for (int i = 0; i < NREQ; i++)
         chk($sformatf("fair cnt%0d", i), 32'(cnt[i]), 32'd2);

      // Timeout with set and clear colliding on the same edge.
      chk("to pre", 32'(timeout_err), 32'd0);
      for (int i = 0; i < NREQ; i++) din[i] = DW'($urandom);
      val = 4'b0001;
      #1;
      chk("to rdy", 32'(rdy), 32'd1);
      tick();
      exp_req  = ~exp_req;
      exp_src  = 0;
      exp_dout = din[0];
      val      = '0;
      repeat (7) tick();
      chk("to wait7", 32'(timeout_err), 32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("to set_vs_clr", 32'(timeout_err), 32'd1);
      chk("to busy8", 32'(busy), 32'd1);
      repeat (6) tick();
      chk("to busy_late", 32'(busy), 32'd1);
      chk("to req_hold", 32'(req), 32'(exp_req));
      ack = ~ack;
      repeat (3) tick();
      chk("to idle", 32'(busy), 32'd0);
      chk("to sticky", 32'(timeout_err), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("to cleared", 32'(timeout_err), 32'd0);

      // Stray ack toggle in IDLE changes nothing, pointer included.
      ack = ~ack;
      repeat (5) tick();
      chk("spur busy", 32'(busy), 32'd0);
      chk("spur rdy", 32'(rdy), 32'd0);
      chk("spur req", 32'(req), 32'(exp_req));
      chk("spur src", 32'(src), 32'(exp_src));
      chk("spur dout", 32'(dout), 32'(exp_dout));
      xfer('1, 1, 2, DW'($urandom), "spur next");

      // Random traffic against a rotating priority-list model.
      do_reset();
      for (int it = 0; it < 60; it++) begin
         v = NREQ'($urandom_range(0, 15));
         if (v == '0) begin
            if ($urandom_range(0, 1) == 1) ack = ~ack;
            repeat (4) tick();
            chk($sformatf("rnd%0d idle busy", it), 32'(busy), 32'd0);
            chk($sformatf("rnd%0d idle req", it), 32'(req), 32'(exp_req));
            chk($sformatf("rnd%0d idle dout", it), 32'(dout), 32'(exp_dout));
         end else begin
            w = -1;
            foreach (q[j]) if (w < 0 && v[q[j]]) w = q[j];
            while (q[$] != w) q.push_back(q.pop_front());
            xfer(v, w, $urandom_range(0, 3), DW'($urandom), $sformatf("rnd%0d", it));
         end
      end
      chk("rnd timeout", 32'(timeout_err), 32'd0);

      // Reset in the middle of WAIT.
      for (int i = 0; i < NREQ; i++) din[i] = DW'($urandom);
      val = 4'b0010;
      #1;
      chk("mid rdy", 32'(rdy), 32'b0010);
      tick();
      val = '0;
      repeat (2) tick();
      chk("mid busy", 32'(busy), 32'd1);
      rst_b = 1'b0;
      #1;
      chk("mid rst req", 32'(req), 32'd0);
      chk("mid rst busy", 32'(busy), 32'd0);
      ack = 1'b0;
      val = 4'b1001;
      #1;
      chk("mid rst rdy", 32'(rdy), 32'd0);
      repeat (2) tick();
      rst_b = 1'b1;
      #1;
      chk("mid rel rdy", 32'(rdy), 32'b0001);
      tick();
      chk("mid rel src", 32'(src), 32'd0);
      chk("mid rel req", 32'(req), 32'd1);
      chk("mid rel busy", 32'(busy), 32'd1);
      val = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
